// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encoding and flag
// bit positions used by both the ALU and the control-unit decoder.
package alu_seq_pkg;

    localparam logic [3:0] OP_FWD = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_OVF   = 3;
    localparam int FLAG_W     = 4;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bundle between the control unit (master) and the ALU (slave).
interface alu_seq_if #(parameter int WIDTH = 8);

    logic             start;
    logic [3:0]       select;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             neg;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, select, data1, data2,
        input  result, zero, carry, neg, ovf, busy, done
    );

    modport slave (
        input  start, select, data1, data2,
        output result, zero, carry, neg, ovf, busy, done
    );

endinterface

// File: rtl/alu_seq_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA/ROR; out-of-range amounts
// saturate for the linear shifts while ROR wraps modulo WIDTH.
module alu_seq_shifter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] amount,
    output logic [WIDTH-1:0] shifted
);

    localparam int SHW = $clog2(WIDTH);

    logic             big_s;
    logic [SHW-1:0]   sh_s;
    logic [2*WIDTH-1:0] rot_s;

    // WIDTH is a power of two, so any set bit above the index field means amount >= WIDTH
    assign big_s = |amount[WIDTH-1:SHW];
    assign sh_s  = amount[SHW-1:0];
    assign rot_s = {value, value} >> sh_s;

    // Select shift flavour and apply saturation
    always_comb begin
        shifted = '0;
        case (op)
            OP_SLL: begin
                if (big_s) shifted = '0;
                else       shifted = value << sh_s;
            end
            OP_SRL: begin
                if (big_s) shifted = '0;
                else       shifted = value >> sh_s;
            end
            OP_SRA: begin
                if (big_s) shifted = {WIDTH{value[WIDTH-1]}};
                else       shifted = WIDTH'($signed(value) >>> sh_s);
            end
            OP_ROR:  shifted = rot_s[WIDTH-1:0];
            default: shifted = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with single-cycle ops and an iterative shift-add multiplier;
// START/BUSY/DONE lets the control unit stall while MUL iterates.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_e               state_r, state_n;
    logic [WIDTH-1:0]     result_r;
    logic [FLAG_W-1:0]    flags_r;
    logic                 busy_r, done_r;
    logic [2*WIDTH-1:0]   mcand_r, acc_r, acc_next_s;
    logic [WIDTH-1:0]     mplier_r;
    logic [SHW-1:0]       cnt_r;

    logic [WIDTH-1:0]     shift_s, alu_res_s, res_s;
    logic [WIDTH:0]       sum_s, diff_s;
    logic                 alu_carry_s, alu_ovf_s, carry_s, ovf_s;
    logic                 load_s, mul_start_s, mul_step_s;

    alu_seq_shifter #(.WIDTH(WIDTH)) u_shifter (
        .op      (bus.select),
        .value   (bus.data1),
        .amount  (bus.data2),
        .shifted (shift_s)
    );

    assign sum_s      = {1'b0, bus.data1} + {1'b0, bus.data2};
    assign diff_s     = {1'b0, bus.data1} - {1'b0, bus.data2};
    assign acc_next_s = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});

    // Single-cycle datapath; MUL and illegal opcodes yield zero here
    always_comb begin
        alu_res_s   = '0;
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
        case (bus.select)
            OP_FWD: alu_res_s = bus.data2;
            OP_ADD: begin
                alu_res_s   = sum_s[WIDTH-1:0];
                alu_carry_s = sum_s[WIDTH];
                alu_ovf_s   = (bus.data1[WIDTH-1] == bus.data2[WIDTH-1]) &&
                              (sum_s[WIDTH-1] != bus.data1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s   = diff_s[WIDTH-1:0];
                alu_carry_s = diff_s[WIDTH];
                alu_ovf_s   = (bus.data1[WIDTH-1] != bus.data2[WIDTH-1]) &&
                              (diff_s[WIDTH-1] != bus.data1[WIDTH-1]);
            end
            OP_AND: alu_res_s = bus.data1 & bus.data2;
            OP_OR:  alu_res_s = bus.data1 | bus.data2;
            OP_SLL, OP_SRL, OP_SRA, OP_ROR: alu_res_s = shift_s;
            default: alu_res_s = '0;
        endcase
    end

    // FSM next-state and load/step controls
    always_comb begin
        state_n     = state_r;
        load_s      = 1'b0;
        mul_start_s = 1'b0;
        mul_step_s  = 1'b0;
        res_s       = '0;
        carry_s     = 1'b0;
        ovf_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_mul(bus.select)) begin
                        mul_start_s = 1'b1;
                        state_n     = ST_MUL;
                    end else begin
                        load_s  = 1'b1;
                        res_s   = alu_res_s;
                        carry_s = alu_carry_s;
                        ovf_s   = alu_ovf_s;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_MUL: begin
                mul_step_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    load_s  = 1'b1;
                    res_s   = acc_next_s[WIDTH-1:0];
                    ovf_s   = |acc_next_s[2*WIDTH-1:WIDTH];
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_MUL;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State, result/flag registers and multiplier iterator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            result_r <= '0;
            flags_r  <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
        end else begin
            state_r <= state_n;
            busy_r  <= (state_n == ST_MUL);
            done_r  <= load_s;
            if (load_s) begin
                result_r            <= res_s;
                flags_r[FLAG_ZERO]  <= (res_s == '0);
                flags_r[FLAG_CARRY] <= carry_s;
                flags_r[FLAG_NEG]   <= res_s[WIDTH-1];
                flags_r[FLAG_OVF]   <= ovf_s;
            end
            if (mul_start_s) begin
                mcand_r  <= {{WIDTH{1'b0}}, bus.data1};
                mplier_r <= bus.data2;
                acc_r    <= '0;
                cnt_r    <= '0;
            end else if (mul_step_s) begin
                acc_r    <= acc_next_s;
                mcand_r  <= mcand_r << 1;
                mplier_r <= mplier_r >> 1;
                cnt_r    <= cnt_r + 1'b1;
            end
        end
    end

    assign bus.result = result_r;
    assign bus.zero   = flags_r[FLAG_ZERO];
    assign bus.carry  = flags_r[FLAG_CARRY];
    assign bus.neg    = flags_r[FLAG_NEG];
    assign bus.ovf    = flags_r[FLAG_OVF];
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8; flags are compared as
// {zero, carry, neg, ovf}.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {bus.zero, bus.carry, bus.neg, bus.ovf};
    endfunction

    task automatic single(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_res, input logic [3:0] exp_flg);
        bus.start = 1'b1; bus.select = op; bus.data1 = a; bus.data2 = b;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " done"}, {31'd0, bus.done}, 32'd1);
        check({tag, " result"}, {24'd0, bus.result}, {24'd0, exp_res});
        check({tag, " flags"}, {28'd0, flags()}, {28'd0, exp_flg});
        @(negedge clk);
        check({tag, " done drop"}, {31'd0, bus.done}, 32'd0);
        check({tag, " hold"}, {24'd0, bus.result}, {24'd0, exp_res});
    endtask

    task automatic mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_res, input logic [3:0] exp_flg);
        int cycles;
        int busy_cnt;
        bus.start = 1'b1; bus.select = OP_MUL; bus.data1 = a; bus.data2 = b;
        @(negedge clk);
        bus.start = 1'b0;
        cycles = 1;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.done && cycles < 20) begin
            // operand changes and START pulses while busy must be ignored
            if (cycles == 2 || cycles == 4) begin
                bus.start = 1'b1; bus.select = OP_ADD; bus.data1 = 8'hFF; bus.data2 = 8'h11;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cycles++;
            if (bus.busy) busy_cnt++;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, cycles, 32'd9);
        check({tag, " busy cycles"}, busy_cnt, 32'd8);
        check({tag, " result"}, {24'd0, bus.result}, {24'd0, exp_res});
        check({tag, " flags"}, {28'd0, flags()}, {28'd0, exp_flg});
        check({tag, " busy low"}, {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check({tag, " done drop"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.select = 4'd0; bus.data1 = 8'd0; bus.data2 = 8'd0;
        #12;
        check("reset result", {24'd0, bus.result}, 32'd0);
        check("reset flags", {28'd0, flags()}, 32'd0);
        check("reset busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        single("add ovf",   OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0011);
        single("add carry", OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1100);
        single("sub borrow", OP_SUB, 8'h05, 8'h07, 8'hFE, 4'b0110);
        single("sub zero",  OP_SUB, 8'h33, 8'h33, 8'h00, 4'b1000);
        single("sll 3",     OP_SLL, 8'h96, 8'd3,   8'hB0, 4'b0010);
        single("sra 2",     OP_SRA, 8'h96, 8'd2,   8'hE5, 4'b0010);
        single("srl 9",     OP_SRL, 8'h96, 8'd9,   8'h00, 4'b1000);
        single("sra 200",   OP_SRA, 8'h96, 8'd200, 8'hFF, 4'b0010);
        single("ror 11",    OP_ROR, 8'h96, 8'd11,  8'hD2, 4'b0010);
        single("fwd",       OP_FWD, 8'hC3, 8'h5A,  8'h5A, 4'b0000);
        single("illegal",   4'd12,  8'h7F, 8'h01,  8'h00, 4'b1000);

        mul("mul 0d*0b", 8'h0D, 8'h0B, 8'h8F, 4'b0010);
        mul("mul 20*10", 8'h20, 8'h10, 8'h00, 4'b1001);

        // back-to-back single-cycle ops with START held high
        bus.start = 1'b1; bus.select = OP_AND; bus.data1 = 8'hF0; bus.data2 = 8'h3C;
        @(negedge clk);
        check("b2b and done", {31'd0, bus.done}, 32'd1);
        check("b2b and", {24'd0, bus.result}, 32'h30);
        bus.select = OP_OR;
        @(negedge clk);
        check("b2b or done", {31'd0, bus.done}, 32'd1);
        check("b2b or", {24'd0, bus.result}, 32'hFC);
        bus.select = OP_FWD; bus.data2 = 8'h00;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b fwd done", {31'd0, bus.done}, 32'd1);
        check("b2b fwd", {24'd0, bus.result}, 32'h00);
        check("b2b fwd flags", {28'd0, flags()}, 32'h8);
        @(negedge clk);
        check("b2b done drop", {31'd0, bus.done}, 32'd0);

        // reset in the middle of a multiply
        bus.start = 1'b1; bus.select = OP_MUL; bus.data1 = 8'hFF; bus.data2 = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid mul busy", {31'd0, bus.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort result", {24'd0, bus.result}, 32'd0);
        check("abort flags", {28'd0, flags()}, 32'd0);
        check("abort busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("no done after abort", {31'd0, bus.done}, 32'd0);
        end
        single("add after reset", OP_ADD, 8'h12, 8'h34, 8'h46, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
